multicycle_alu_sequencer: RTL and testbench
===========================================

// Module: multicycle_alu_sequencer
// PURPOSE
//  Multi-cycle controller for the ALU/register-file datapath. Runs one instruction at a time through
//  FETCH -> DECODE -> EXEC -> WB and raises one-cycle datapath strobes (IRWrite, RegWrite, PCWrite).
//  Supports the same ALU instruction subset as the single-cycle decoder; anything else is a sticky fault.
//  Sits between the instruction-memory handshake and the register-file/ALU datapath.
// PARAMETERS
//  ALU_LAT        1   EXEC dwell in cycles (1..15); 1 = EXEC lasts exactly one cycle
//  FETCH_TIMEOUT  16  max cycles FETCH waits for imem_ack before faulting (1..255)
// PORTS
//  CLK           in   1   clock; all state changes on rising edge
//  Reset_L       in   1   synchronous, active-low reset
//  imem_req      out  1   fetch request; high throughout FETCH
//  imem_ack      in   1   instruction word valid this cycle; only sampled while in FETCH
//  imem_rdata    in   32  instruction word; captured into IR when imem_ack=1 in FETCH
//  halt_req      in   1   level; sampled only in WB and HALT
//  IR            out  32  latched instruction register
//  IRWrite       out  1   one-cycle pulse on the IR capture edge
//  ALUSrcB       out  1   1 = immediate/shamt operand; held valid in EXEC and WB
//  RegDst        out  1   1 = rd, 0 = rt; held valid in EXEC and WB
//  ALUOp         out  4   ALU operation code (shared ALU op defines); `NOP outside EXEC/WB
//  RegWrite      out  1   one-cycle pulse in WB
//  PCWrite       out  1   one-cycle pulse in WB (PC += 4 in datapath)
//  state         out  3   FETCH=0 DECODE=1 EXEC=2 WB=3 HALT=4 FAULT=5
//  fault         out  1   sticky; set on FAULT entry
//  fault_code    out  2   0 none, 1 illegal opcode, 2 illegal R-type funct, 3 fetch timeout
//  retired       out  32  count of completed WB cycles; wraps 0xFFFFFFFF -> 0
// BEHAVIOUR
//  Reset (Reset_L=0 at edge): state=FETCH, IR=0, timer=0, fault=0, fault_code=0, retired=0.
//   All strobes 0, ALUOp=`NOP, ALUSrcB=0, RegDst=0. Reset wins in every state, including FAULT.
//   imem_req=1 in the first cycle after reset release.
//  FETCH: imem_req=1. imem_ack=1: IR<=imem_rdata, IRWrite=1 that cycle, next DECODE, timer cleared.
//   No ack: timer++. If the timer reaches FETCH_TIMEOUT with no ack, next FAULT, code 3.
//   An ack on the cycle the timer hits FETCH_TIMEOUT is accepted; the ack wins.
//  DECODE (1 cycle): classify IR[31:26], IR[5:0].
//   R-type 000000 with funct ADD/ADDU/SUB/SUBU/AND/OR/XOR (100000..100110): ALUSrcB=0, RegDst=1.
//   R-type SLL/SRL/SRA (000000/000010/000011): ALUSrcB=1, RegDst=1.
//   ADDI 001000 / ADDIU 001001 / ANDI 001100 / ORI 001101 / XORI 001110: ALUSrcB=1, RegDst=0.
//   Other R-type funct: FAULT, code 2. Other opcode: FAULT, code 1. Otherwise next EXEC.
//   ALUOp map: ADD/ADDI->`ADD, ADDU/ADDIU->`ADDU, AND/ANDI->`AND, OR/ORI->`OR, XOR/XORI->`XOR,
//   SUB->`SUB, SUBU->`SUBU, SLL->`SLL, SRL->`SRL, SRA->`SRA.
//  Decoded controls are registered at the DECODE->EXEC edge and held through WB.
//  EXEC: ALUOp/ALUSrcB/RegDst stable; dwell ALU_LAT cycles (down-counter), then WB.
//  WB (1 cycle): RegWrite=1, PCWrite=1, retired++.
//   Next state HALT if halt_req=1, else FETCH. All-zero IR (sll $0,$0,0) is legal and writes $0.
//  HALT: all strobes 0, imem_req=0, ALUOp=`NOP. Next FETCH on the first cycle halt_req=0.
//  FAULT: terminal until reset. Strobes 0, imem_req=0, IR frozen.
//   fault=1 and fault_code are set on the FAULT entry edge.
//  Invariant: IRWrite, RegWrite and PCWrite are never high outside their stated states.
//   RegWrite and PCWrite are each exactly one pulse per retired instruction.
//  Latency, ack in first FETCH cycle: 1 + 1 + ALU_LAT + 1 cycles per instruction (4 at default).
// TESTING
//  T1 reset, ack every FETCH, IR=0x01095020 (add $10,$8,$9) -> IRWrite@c0, EXEC ALUOp=`ADD,
//     ALUSrcB=0, RegDst=1; RegWrite and PCWrite only @c3; retired=1.
//  T2 IR=0x3508FFFF (ori) then 0x00084080 (sll), ALU_LAT=3 -> ALUOp `OR, then `SLL; ALUSrcB=1 both;
//     RegDst=0 then 1; each instruction takes 6 cycles.
//  T3 IR=0x8C080000 (lw) -> FAULT after DECODE, fault_code=1, no RegWrite/PCWrite;
//     IR=0x0000000C (funct 001100) -> fault_code=2.
//  T4 imem_ack held low -> FAULT after exactly 16 FETCH cycles, code 3; ack on the 16th cycle -> no fault.
//  T5 halt_req=1 during WB -> HALT, imem_req=0; release after 5 cycles -> FETCH the next cycle; retired unchanged in HALT.
//  T6 Reset_L=0 mid-EXEC and in FAULT -> next cycle FETCH, fault=0, retired=0, no strobes.
//     Preload retired to 0xFFFFFFFF (force) -> wraps to 0 after next WB.

Source files
------------

// File: rtl/multicycle_alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the ALU/register-file datapath.
// Raises one-cycle IRWrite/RegWrite/PCWrite strobes; illegal instructions and fetch timeouts fault.

`ifndef NOP
`define NOP  4'd0
`define ADD  4'd1
`define ADDU 4'd2
`define SUB  4'd3
`define SUBU 4'd4
`define AND  4'd5
`define OR   4'd6
`define XOR  4'd7
`define SLL  4'd8
`define SRL  4'd9
`define SRA  4'd10
`endif

module multicycle_alu_sequencer #(
  parameter int ALU_LAT       = 1,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        Reset_L,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        halt_req,
  output logic [31:0] IR,
  output logic        IRWrite,
  output logic        ALUSrcB,
  output logic        RegDst,
  output logic [3:0]  ALUOp,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic [2:0]  state,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    Fetch  = 3'd0,
    Decode = 3'd1,
    Exec   = 3'd2,
    Wb     = 3'd3,
    Halt   = 3'd4,
    Fault  = 3'd5
  } seqState_t;

  seqState_t   curState, nextState;
  logic [7:0]  fetchTimer;
  logic [3:0]  execCnt;
  logic [3:0]  opReg, decOp;
  logic        srcBReg, dstReg, decSrcB, decDst;
  logic [1:0]  decCode, newCode;
  logic        aluActive;

  // Instruction classification; a nonzero decCode names the fault class.
  always_comb begin
    decOp   = `NOP;
    decSrcB = 1'b0;
    decDst  = 1'b0;
    decCode = 2'd0;
    if (IR[31:26] == 6'b000000) begin
      decDst = 1'b1;
      case (IR[5:0])
        6'b100000: decOp = `ADD;
        6'b100001: decOp = `ADDU;
        6'b100010: decOp = `SUB;
        6'b100011: decOp = `SUBU;
        6'b100100: decOp = `AND;
        6'b100101: decOp = `OR;
        6'b100110: decOp = `XOR;
        6'b000000: begin decOp = `SLL; decSrcB = 1'b1; end
        6'b000010: begin decOp = `SRL; decSrcB = 1'b1; end
        6'b000011: begin decOp = `SRA; decSrcB = 1'b1; end
        default:   decCode = 2'd2;
      endcase
    end else begin
      decSrcB = 1'b1;
      case (IR[31:26])
        6'b001000: decOp = `ADD;
        6'b001001: decOp = `ADDU;
        6'b001100: decOp = `AND;
        6'b001101: decOp = `OR;
        6'b001110: decOp = `XOR;
        default:   decCode = 2'd1;
      endcase
    end
  end

  always_comb begin
    nextState = curState;
    newCode   = 2'd0;
    case (curState)
      Fetch: begin
        if (imem_ack) begin
          nextState = Decode;
        end else if (fetchTimer == 8'(FETCH_TIMEOUT - 1)) begin
          nextState = Fault;
          newCode   = 2'd3;
        end
      end
      Decode: begin
        if (decCode != 2'd0) begin
          nextState = Fault;
          newCode   = decCode;
        end else begin
          nextState = Exec;
        end
      end
      Exec:    if (execCnt == 4'd0) nextState = Wb;
      Wb:      nextState = halt_req ? Halt : Fetch;
      Halt:    if (!halt_req) nextState = Fetch;
      Fault:   nextState = Fault;
      default: nextState = Fetch;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      curState   <= Fetch;
      IR         <= 32'd0;
      fetchTimer <= 8'd0;
      execCnt    <= 4'd0;
      opReg      <= `NOP;
      srcBReg    <= 1'b0;
      dstReg     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'd0;
      retired    <= 32'd0;
    end else begin
      curState <= nextState;
      case (curState)
        Fetch: begin
          if (imem_ack) begin
            IR         <= imem_rdata;
            fetchTimer <= 8'd0;
          end else begin
            fetchTimer <= fetchTimer + 8'd1;
          end
        end
        Decode: begin
          opReg   <= decOp;
          srcBReg <= decSrcB;
          dstReg  <= decDst;
          execCnt <= 4'(ALU_LAT - 1);
        end
        Exec:    if (execCnt != 4'd0) execCnt <= execCnt - 4'd1;
        Wb:      retired <= retired + 32'd1;
        default: ;
      endcase
      if (nextState == Fault && curState != Fault) begin
        fault      <= 1'b1;
        fault_code <= newCode;
      end
    end
  end

  // Decoded controls are only presented to the datapath while EXEC/WB use them.
  assign aluActive = (curState == Exec) || (curState == Wb);
  assign ALUOp     = aluActive ? opReg : `NOP;
  assign ALUSrcB   = aluActive & srcBReg;
  assign RegDst    = aluActive & dstReg;
  assign imem_req  = (curState == Fetch);
  assign IRWrite   = (curState == Fetch) & imem_ack;
  assign RegWrite  = (curState == Wb);
  assign PCWrite   = (curState == Wb);
  assign state     = curState;

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// Directed testbench for multicycle_alu_sequencer: default-latency instance plus an ALU_LAT=3
// instance sharing the same stimulus; expected values are hand-derived per cycle.

module tb_multicycle_alu_sequencer;

  localparam logic [3:0] opNop = 4'd0;
  localparam logic [3:0] opAdd = 4'd1;
  localparam logic [3:0] opOr  = 4'd6;
  localparam logic [3:0] opSll = 4'd8;

  logic        CLK;
  logic        Reset_L;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        halt_req;

  logic        imem_req, IRWrite, ALUSrcB, RegDst, RegWrite, PCWrite, fault;
  logic [31:0] IR, retired;
  logic [3:0]  ALUOp;
  logic [2:0]  state;
  logic [1:0]  fault_code;

  logic        imem_req3, IRWrite3, ALUSrcB3, RegDst3, RegWrite3, PCWrite3, fault3;
  logic [31:0] IR3, retired3;
  logic [3:0]  ALUOp3;
  logic [2:0]  state3;
  logic [1:0]  fault_code3;

  int compareCount  = 0;
  int mismatchCount = 0;

  int t2State[13] = '{0, 1, 2, 2, 2, 3, 0, 1, 2, 2, 2, 3, 0};
  int t2Op[13]    = '{0, 0, 6, 6, 6, 6, 0, 0, 8, 8, 8, 8, 0};
  int t2SrcB[13]  = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
  int t2Dst[13]   = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0};

  multicycle_alu_sequencer dut (
    .CLK(CLK), .Reset_L(Reset_L), .imem_req(imem_req), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .halt_req(halt_req), .IR(IR), .IRWrite(IRWrite),
    .ALUSrcB(ALUSrcB), .RegDst(RegDst), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .PCWrite(PCWrite), .state(state), .fault(fault), .fault_code(fault_code),
    .retired(retired)
  );

  multicycle_alu_sequencer #(.ALU_LAT(3), .FETCH_TIMEOUT(16)) dutLat3 (
    .CLK(CLK), .Reset_L(Reset_L), .imem_req(imem_req3), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .halt_req(halt_req), .IR(IR3), .IRWrite(IRWrite3),
    .ALUSrcB(ALUSrcB3), .RegDst(RegDst3), .ALUOp(ALUOp3), .RegWrite(RegWrite3),
    .PCWrite(PCWrite3), .state(state3), .fault(fault3), .fault_code(fault_code3),
    .retired(retired3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic rstN, input logic ack, input logic [31:0] rdata,
                               input logic halt);
    @(negedge CLK);
    Reset_L    = rstN;
    imem_ack   = ack;
    imem_rdata = rdata;
    halt_req   = halt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    Reset_L    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    halt_req   = 1'b0;
    doReset();

    // T1: add $10,$8,$9 with immediate ack
    applyStimulus(1'b1, 1'b1, 32'h01095020, 1'b0);
    checkOutput("T1 reset state", 32'(state), 32'd0);
    checkOutput("T1 reset IR", IR, 32'd0);
    checkOutput("T1 reset retired", retired, 32'd0);
    checkOutput("T1 reset fault", 32'(fault), 32'd0);
    checkOutput("T1 reset ALUOp", 32'(ALUOp), 32'(opNop));
    checkOutput("T1 imem_req c0", 32'(imem_req), 32'd1);
    checkOutput("T1 IRWrite c0", 32'(IRWrite), 32'd1);
    checkOutput("T1 RegWrite c0", 32'(RegWrite), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T1 state c1", 32'(state), 32'd1);
    checkOutput("T1 IR c1", IR, 32'h01095020);
    checkOutput("T1 IRWrite c1", 32'(IRWrite), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T1 state c2", 32'(state), 32'd2);
    checkOutput("T1 ALUOp c2", 32'(ALUOp), 32'(opAdd));
    checkOutput("T1 ALUSrcB c2", 32'(ALUSrcB), 32'd0);
    checkOutput("T1 RegDst c2", 32'(RegDst), 32'd1);
    checkOutput("T1 RegWrite c2", 32'(RegWrite), 32'd0);
    checkOutput("T1 PCWrite c2", 32'(PCWrite), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T1 state c3", 32'(state), 32'd3);
    checkOutput("T1 RegWrite c3", 32'(RegWrite), 32'd1);
    checkOutput("T1 PCWrite c3", 32'(PCWrite), 32'd1);
    checkOutput("T1 ALUOp c3", 32'(ALUOp), 32'(opAdd));
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T1 state c4", 32'(state), 32'd0);
    checkOutput("T1 RegWrite c4", 32'(RegWrite), 32'd0);
    checkOutput("T1 retired c4", retired, 32'd1);
    checkOutput("T1 ALUOp c4", 32'(ALUOp), 32'(opNop));

    // T2: ori then sll on the ALU_LAT=3 instance
    doReset();
    for (int c = 0; c < 13; c++) begin
      applyStimulus(1'b1, (c == 0 || c == 6),
                    (c == 0) ? 32'h3508FFFF : ((c == 6) ? 32'h00084080 : 32'd0), 1'b0);
      checkOutput($sformatf("T2 state c%0d", c), 32'(state3), 32'(t2State[c]));
      checkOutput($sformatf("T2 ALUOp c%0d", c), 32'(ALUOp3), 32'(t2Op[c]));
      checkOutput($sformatf("T2 ALUSrcB c%0d", c), 32'(ALUSrcB3), 32'(t2SrcB[c]));
      checkOutput($sformatf("T2 RegDst c%0d", c), 32'(RegDst3), 32'(t2Dst[c]));
      checkOutput($sformatf("T2 RegWrite c%0d", c), 32'(RegWrite3), 32'(t2State[c] == 3));
    end
    checkOutput("T2 retired", retired3, 32'd2);
    checkOutput("T2 ALUOp or code", 32'(opOr), 32'(t2Op[3]));
    checkOutput("T2 ALUOp sll code", 32'(opSll), 32'(t2Op[9]));

    // T3: illegal opcode (lw) and illegal funct
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h8C080000, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T3 lw decode state", 32'(state), 32'd1);
    applyStimulus(1'b1, 1'b1, 32'd0, 1'b0);
    checkOutput("T3 lw fault state", 32'(state), 32'd5);
    checkOutput("T3 lw fault", 32'(fault), 32'd1);
    checkOutput("T3 lw fault_code", 32'(fault_code), 32'd1);
    checkOutput("T3 lw RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("T3 lw PCWrite", 32'(PCWrite), 32'd0);
    checkOutput("T3 lw imem_req", 32'(imem_req), 32'd0);
    checkOutput("T3 lw IRWrite", 32'(IRWrite), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T3 lw IR frozen", IR, 32'h8C080000);
    checkOutput("T3 lw fault sticky", 32'(state), 32'd5);
    doReset();
    applyStimulus(1'b1, 1'b1, 32'h0000000C, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T3 funct fault state", 32'(state), 32'd5);
    checkOutput("T3 funct fault_code", 32'(fault_code), 32'd2);

    // T4: fetch timeout, then ack on the last allowed cycle
    doReset();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
      checkOutput($sformatf("T4 fetch wait %0d", k), 32'(state), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T4 timeout state", 32'(state), 32'd5);
    checkOutput("T4 timeout fault_code", 32'(fault_code), 32'd3);
    doReset();
    for (int k = 0; k < 15; k++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h01095020, 1'b0);
    checkOutput("T4 late ack state", 32'(state), 32'd0);
    checkOutput("T4 late ack IRWrite", 32'(IRWrite), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T4 late ack decode", 32'(state), 32'd1);
    checkOutput("T4 late ack no fault", 32'(fault), 32'd0);

    // T5: halt requested during WB, released after five HALT cycles
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("T5 exec state", 32'(state), 32'd2);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    checkOutput("T5 wb state", 32'(state), 32'd3);
    checkOutput("T5 wb RegWrite", 32'(RegWrite), 32'd1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
      checkOutput($sformatf("T5 halt state %0d", k), 32'(state), 32'd4);
      checkOutput($sformatf("T5 halt imem_req %0d", k), 32'(imem_req), 32'd0);
      checkOutput($sformatf("T5 halt ALUOp %0d", k), 32'(ALUOp), 32'(opNop));
      checkOutput($sformatf("T5 halt retired %0d", k), retired, 32'd1);
      checkOutput($sformatf("T5 halt PCWrite %0d", k), 32'(PCWrite), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T5 release state", 32'(state), 32'd4);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T5 resume state", 32'(state), 32'd0);
    checkOutput("T5 resume imem_req", 32'(imem_req), 32'd1);

    // T6: reset mid-EXEC, reset in FAULT, retired wrap
    applyStimulus(1'b1, 1'b1, 32'h01095020, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("T6 pre-reset exec", 32'(state), 32'd2);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T6 exec reset state", 32'(state), 32'd0);
    checkOutput("T6 exec reset retired", retired, 32'd0);
    checkOutput("T6 exec reset IR", IR, 32'd0);
    checkOutput("T6 exec reset RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("T6 exec reset ALUOp", 32'(ALUOp), 32'(opNop));
    applyStimulus(1'b1, 1'b1, 32'h8C080000, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("T6 pre-reset fault", 32'(fault), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T6 fault reset state", 32'(state), 32'd0);
    checkOutput("T6 fault reset fault", 32'(fault), 32'd0);
    checkOutput("T6 fault reset code", 32'(fault_code), 32'd0);
    checkOutput("T6 fault reset imem_req", 32'(imem_req), 32'd1);
    force dut.retired = 32'hFFFFFFFF;
    #1;
    release dut.retired;
    applyStimulus(1'b1, 1'b1, 32'h01095020, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T6 wrap wb", 32'(RegWrite), 32'd1);
    checkOutput("T6 wrap pre", retired, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    checkOutput("T6 wrap retired", retired, 32'd0);
    checkOutput("T6 wrap state", 32'(state), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
